// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier slice.
// Holds the controller state encoding, the counter-width helper and msb_index.
// No ports; imported by the multiplier top and by the bench model.
package mult_pkg;

  // Two-state controller. "Done" is a registered pulse, not a state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest operand the datapath is meant to be built for.
  localparam int MAX_WIDTH = 32;

  // Iteration counter width: it must be able to hold the value WIDTH itself,
  // because completion is detected by comparing cnt+1 against WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Bit index of the most significant set bit. A zero value returns 0,
  // which makes max(1, msb_index(v)+1) come out as 1 for v == 0.
  function automatic int msb_index(input logic [63:0] value);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/gated_ripple_adder.sv
// Enable-gated ripple-carry adder: sum = a + (b & {N{en}}) + cin.
// Ports: a, b (N bits), en (gates every bit of b), cin; outputs sum (N bits), cout.
// Purely combinational; built as a generate chain of full-adder cells.
module gated_ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         en,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic b_gated;
    logic half_sum;

    assign b_gated      = b[i] & en;
    assign half_sum     = a[i] ^ b_gated;
    assign sum[i]       = half_sum ^ carry[i];
    assign carry[i + 1] = (a[i] & b_gated) | (carry[i] & half_sum);
  end

  assign cout = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier using repeated gated add-and-shift.
// Ports: clk, rst (sync, active high), start/busy/done handshake, multiplicand,
//        multiplier (WIDTH bits), product (2*WIDTH bits, held until next accept).
// Build option: define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                PW       = 2 * WIDTH;
  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH);

  state_e            state_q, state_d;
  logic [PW-1:0]     mc_q, mc_d;
  logic [WIDTH-1:0]  mp_q, mp_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PW-1:0]     add_sum;
  logic              add_cout_unused;
  logic [WIDTH-1:0]  mp_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_step;

  // The 2*WIDTH-bit accumulator cannot overflow for WIDTH-bit operands,
  // so the adder carry-out is deliberately left unconnected downstream.
  gated_ripple_adder #(
    .N (PW)
  ) u_adder (
    .a    (acc_q),
    .b    (mc_q),
    .en   (mp_q[0]),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  assign mp_shift = mp_q >> 1;
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef EARLY_TERM_EN
  // Once no set multiplier bits remain, further iterations would add zero.
  assign last_step = (cnt_inc == LAST_CNT) || (mp_shift == '0);
`else
  assign last_step = (cnt_inc == LAST_CNT);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)     state_d = RUN;
      RUN:  if (last_step) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath and handshake next-state logic
  always_comb begin
    mc_d      = mc_q;
    mp_d      = mp_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mc_d   = {{WIDTH{1'b0}}, multiplicand};
          mp_d   = multiplier;
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        acc_d = add_sum;
        mc_d  = mc_q << 1;
        mp_d  = mp_shift;
        cnt_d = cnt_inc;
        if (last_step) begin
          product_d = add_sum;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_q      <= '0;
      mp_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=8 and WIDTH=16.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  logic        clk;
  logic        rst;
  logic        start8,  start16;
  logic [7:0]  mc8,  mp8;
  logic [15:0] mc16, mp16;
  logic        busy8,  done8,  busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int checks;
  int errors;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .multiplicand (mc8),
    .multiplier   (mp8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .multiplicand (mc16),
    .multiplier   (mp16),
    .busy         (busy16),
    .done         (done16),
    .product      (prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge until done is visible.
  function automatic int exp_lat(input int w, input logic [63:0] mp);
`ifdef EARLY_TERM_EN
    int l;
    l = msb_index(mp) + 1;
    if (l > w) l = w;
    return (l < 1) ? 1 : l;
`else
    return w + 0 * msb_index(mp);
`endif
  endfunction

  // Step edges until done8 rises (bounded); busy must stay high meanwhile.
  task automatic wait_done8(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done8) check({tag, "_busy"}, 64'(busy8), 64'd1);
    end while (!done8 && n < 40);
    check({tag, "_done_seen"}, 64'(done8), 64'd1);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_p);
    int n;
    start8 = 1'b1; mc8 = a; mp8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; mc8 = ~a; mp8 = ~b;
    check({tag, "_busy_acc"}, 64'(busy8), 64'd1);
    wait_done8(tag, n);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat(8, 64'(b))));
    check({tag, "_prod"}, 64'(prod8), 64'(exp_p));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 64'(done8), 64'd0);
    check({tag, "_idle"}, 64'(busy8), 64'd0);
    check({tag, "_hold"}, 64'(prod8), 64'(exp_p));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    mc8 = '0; mp8 = '0; mc16 = '0; mp16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8",  64'(busy8),  64'd0);
    check("rst_done8",  64'(done8),  64'd0);
    check("rst_prod8",  64'(prod8),  64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_prod16", 64'(prod16), 64'd0);
    rst = 1'b0;

    run8("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run8("00_a5", 8'h00, 8'hA5, 16'h0000);
    run8("a5_00", 8'hA5, 8'h00, 16'h0000);
    run8("37_05", 8'h37, 8'h05, 16'h0113);

    // start re-pulsed while busy and operands changed mid-run
    start8 = 1'b1; mc8 = 8'h12; mp8 = 8'h34;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start8 = 1'b1; mc8 = 8'hFF; mp8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0; mc8 = 8'hAA; mp8 = 8'h55;
    check("busy_ign_busy", 64'(busy8), 64'd1);
    wait_done8("busy_ign", n);
    check("busy_ign_lat", 64'(n + 3), 64'(exp_lat(8, 64'h34)));
    check("busy_ign_prod", 64'(prod8), 64'h03A8);
    repeat (2) begin
      @(posedge clk); #1;
      check("busy_ign_nosecond", 64'(busy8), 64'd0);
    end
    check("busy_ign_hold", 64'(prod8), 64'h03A8);

    // reset mid-operation
    start8 = 1'b1; mc8 = 8'hFF; mp8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_prod", 64'(prod8), 64'd0);
    run8("02_03", 8'h02, 8'h03, 16'h0006);

    // back-to-back with start held across done
    start8 = 1'b1; mc8 = 8'h0F; mp8 = 8'h0F;
    @(posedge clk); #1;
    mc8 = 8'h10; mp8 = 8'h10;
    wait_done8("b2b1", n);
    check("b2b1_lat", 64'(n), 64'(exp_lat(8, 64'h0F)));
    check("b2b1_prod", 64'(prod8), 64'h00E1);
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b2_acc_busy", 64'(busy8), 64'd1);
    check("b2b2_acc_done", 64'(done8), 64'd0);
    check("b2b2_acc_hold", 64'(prod8), 64'h00E1);
    wait_done8("b2b2", n);
    check("b2b_gap", 64'(n + 1), 64'(exp_lat(8, 64'h10) + 1));
    check("b2b2_prod", 64'(prod8), 64'h0100);
    @(posedge clk); #1;
    check("b2b2_done_drop", 64'(done8), 64'd0);

    // WIDTH=16 corner
    start16 = 1'b1; mc16 = 16'hFFFF; mp16 = 16'hFFFF;
    @(posedge clk); #1;
    start16 = 1'b0; mc16 = 16'h0; mp16 = 16'h0;
    check("w16_busy", 64'(busy16), 64'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done16 && n < 60);
    check("w16_done_seen", 64'(done16), 64'd1);
    check("w16_lat", 64'(n), 64'(exp_lat(16, 64'hFFFF)));
    check("w16_prod", 64'(prod16), 64'hFFFE0001);
    @(posedge clk); #1;
    check("w16_done_drop", 64'(done16), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
